// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin ALU/MEM write-back arbiter driving a registered regfile
// write port, with a busy-register scoreboard for issue-stage hazard stalls.
module rf_wb_arbiter #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [ADDR_W-1:0]   alu_addr,
    input  logic [DATA_W-1:0]   alu_data,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_data,
    input  logic                rsv_valid,
    input  logic [ADDR_W-1:0]   rsv_addr,
    input  logic [ADDR_W-1:0]   chk_addr_a,
    input  logic [ADDR_W-1:0]   chk_addr_b,
    output logic                hazard,
    output logic                rf_we,
    output logic [ADDR_W-1:0]   rf_waddr,
    output logic [DATA_W-1:0]   rf_wdata,
    output logic                rf_wsrc,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic                err_unrsv
);
    logic                last_grant;
    logic                xfer;
    logic [ADDR_W-1:0]   win_addr;
    logic [NUM_REGS-1:0] set_vec, clr_vec;

    // last_grant: 0=ALU, 1=MEM; on contention the other side wins
    assign alu_ready = alu_valid & (~mem_valid | last_grant);
    assign mem_ready = mem_valid & (~alu_valid | ~last_grant);
    assign xfer      = alu_ready | mem_ready;
    assign win_addr  = mem_ready ? mem_addr : alu_addr;
    assign hazard    = rsv_valid & (busy_vec[chk_addr_a] | busy_vec[chk_addr_b] | busy_vec[rsv_addr]);

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (rf_we) clr_vec[rf_waddr] = 1'b1;
        if (rsv_valid && !hazard) set_vec[rsv_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            rf_wsrc    <= 1'b0;
            busy_vec   <= '0;
            err_unrsv  <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            if (xfer) begin
                rf_waddr   <= win_addr;
                rf_wdata   <= mem_ready ? mem_data : alu_data;
                rf_wsrc    <= mem_ready;
                last_grant <= mem_ready;
                if (win_addr != '0 && !busy_vec[win_addr]) err_unrsv <= 1'b1;
            end
            rf_we    <= xfer && win_addr != '0;
            // set wins over a same-edge commit; register 0 never goes busy
            busy_vec <= ((busy_vec & ~clr_vec) | set_vec) & {{(NUM_REGS-1){1'b1}}, 1'b0};
        end
    end
endmodule
